// File: rtl/multdiv_pkg.sv
// Shared types and constants for the mult/div issue sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } md_op_e;

    localparam logic [4:0]  RSTATUS_REG     = 5'd30;
    localparam int unsigned MUL_EXC_DEFAULT = 4;
    localparam int unsigned DIV_EXC_DEFAULT = 5;

    // Latched request: operation, destination and operands held for multdiv.
    typedef struct packed {
        md_op_e      op;
        logic [4:0]  rd;
        logic [31:0] opa;
        logic [31:0] opb;
    } req_t;

    typedef struct packed {
        logic        exc;
        logic        tmo;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    function automatic logic [31:0] exc_word(md_op_e op, int unsigned mul_code,
                                             int unsigned div_code);
        return (op == OP_DIV) ? 32'(div_code) : 32'(mul_code);
    endfunction

endpackage

// File: rtl/multdiv_issue_if.sv
// Pipeline-side request, multdiv handshake and writeback bundle.
// Latency: n/a (wiring only).
// Backpressure: stall/busy flow from sequencer back to the issuing pipeline.
interface multdiv_issue_if;
    logic        issue_valid;
    logic        issue_is_div;
    logic [31:0] issue_opA;
    logic [31:0] issue_opB;
    logic [4:0]  issue_rd;
    logic        flush;

    logic        stall;
    logic        busy;
    logic [4:0]  busy_rd;

    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
    logic        wb_timeout;

    modport slave (
        input  issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
        input  md_result, md_exception, md_ready,
        output stall, busy, busy_rd,
        output md_operandA, md_operandB, md_ctrl_mult, md_ctrl_div,
        output wb_valid, wb_rd, wb_data, wb_exception, wb_timeout
    );

    modport master (
        output issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd, flush,
        output md_result, md_exception, md_ready,
        input  stall, busy, busy_rd,
        input  md_operandA, md_operandB, md_ctrl_mult, md_ctrl_div,
        input  wb_valid, wb_rd, wb_data, wb_exception, wb_timeout
    );
endinterface

// File: rtl/md_watchdog.sv
// Clearable up-counter bounding the multdiv wait; tc flags the last allowed cycle.
// Latency: count updates one cycle after clr/inc.
// Backpressure: none.
module md_watchdog #(
    parameter int unsigned TIMEOUT = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue.sv
// Execute-stage mult/div sequencer: latches a request, pulses multdiv, writes back result or rstatus code.
// Latency: issue to wb_valid = multdiv cycles + 2; watchdog abandons after TIMEOUT cycles of waiting.
// Backpressure: stall high in START/WAIT; new requests accepted only in IDLE or DONE.
module multdiv_issue
    import multdiv_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 100,
    parameter int unsigned MUL_EXC_CODE = MUL_EXC_DEFAULT,
    parameter int unsigned DIV_EXC_CODE = DIV_EXC_DEFAULT
) (
    input logic            clock,
    input logic            reset,
    multdiv_issue_if.slave bus
);
    state_e      state_q, state_d;
    req_t        req_q, req_d;
    wb_t         wb_q, wb_d;
    logic        wb_valid_q, wb_valid_d;
    logic        stall_q, stall_d;
    logic        busy_q, busy_d;
    logic        ctrl_mult_q, ctrl_mult_d;
    logic        ctrl_div_q, ctrl_div_d;
    logic        accept;
    logic        wd_clr, wd_inc, wd_tc;
    logic [31:0] exc_data;

    assign accept   = bus.issue_valid && !bus.flush && (state_q == IDLE || state_q == DONE);
    assign exc_data = exc_word(req_q.op, MUL_EXC_CODE, DIV_EXC_CODE);

    md_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock (clock),
        .reset (reset),
        .clr   (wd_clr),
        .inc   (wd_inc),
        .tc    (wd_tc)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wb_d    = wb_q;
        wd_clr  = 1'b0;
        wd_inc  = 1'b0;

        // md_ready is only looked at in WAIT: it may still be high from the previous op in START.
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (accept) state_d = START;
                START: begin
                    state_d = WAIT;
                    wd_clr  = 1'b1;
                end
                WAIT: begin
                    if (bus.md_ready) begin
                        state_d = DONE;
                        if (bus.md_exception) begin
                            wb_d = '{exc: 1'b1, tmo: 1'b0, rd: RSTATUS_REG, data: exc_data};
                        end else begin
                            wb_d = '{exc: 1'b0, tmo: 1'b0, rd: req_q.rd, data: bus.md_result};
                        end
                    end else if (wd_tc) begin
                        state_d = DONE;
                        wb_d    = '{exc: 1'b1, tmo: 1'b1, rd: RSTATUS_REG, data: exc_data};
                    end else begin
                        wd_inc = 1'b1;
                    end
                end
                DONE:    state_d = accept ? START : IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (accept) begin
            req_d = '{op:  bus.issue_is_div ? OP_DIV : OP_MULT,
                      rd:  bus.issue_rd,
                      opa: bus.issue_opA,
                      opb: bus.issue_opB};
        end

        stall_d     = (state_d == START) || (state_d == WAIT);
        busy_d      = (state_d != IDLE);
        ctrl_mult_d = (state_d == START) && (req_d.op == OP_MULT);
        ctrl_div_d  = (state_d == START) && (req_d.op == OP_DIV);
        wb_valid_d  = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            wb_q        <= '0;
            wb_valid_q  <= 1'b0;
            stall_q     <= 1'b0;
            busy_q      <= 1'b0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            wb_q        <= wb_d;
            wb_valid_q  <= wb_valid_d;
            stall_q     <= stall_d;
            busy_q      <= busy_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
        end
    end

    assign bus.stall        = stall_q;
    assign bus.busy         = busy_q;
    assign bus.busy_rd      = req_q.rd;
    assign bus.md_operandA  = req_q.opa;
    assign bus.md_operandB  = req_q.opb;
    assign bus.md_ctrl_mult = ctrl_mult_q;
    assign bus.md_ctrl_div  = ctrl_div_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_q.rd;
    assign bus.wb_data      = wb_q.data;
    assign bus.wb_exception = wb_q.exc;
    assign bus.wb_timeout   = wb_q.tmo;

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue with a behavioural multdiv stub of programmable latency.
// Latency: stub raises ready lat+1 cycles after the start pulse, or never when hung.
// Backpressure: stub holds ready high until the next start pulse.
module tb_multdiv_issue;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   md_lat   = 1;
    bit   md_hang  = 1'b0;
    int   md_cnt;
    bit   md_pending;

    multdiv_issue_if ifc();

    multdiv_issue #(.TIMEOUT(100)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural multdiv: result computed from the operands at the start pulse.
    always @(posedge clock) begin
        if (reset) begin
            ifc.md_ready     <= 1'b0;
            ifc.md_result    <= '0;
            ifc.md_exception <= 1'b0;
            md_pending       <= 1'b0;
            md_cnt           <= 0;
        end else if (ifc.md_ctrl_mult || ifc.md_ctrl_div) begin
            logic signed [63:0] pa, pb, prod;
            pa = $signed(ifc.md_operandA);
            pb = $signed(ifc.md_operandB);
            ifc.md_ready <= 1'b0;
            md_pending   <= !md_hang;
            md_cnt       <= md_lat;
            if (ifc.md_ctrl_div) begin
                ifc.md_exception <= (ifc.md_operandB == 32'd0);
                ifc.md_result    <= (ifc.md_operandB == 32'd0) ? 32'd0 : 32'(pa / pb);
            end else begin
                prod = pa * pb;
                ifc.md_result    <= prod[31:0];
                ifc.md_exception <= (prod[63:32] != {32{prod[31]}});
            end
        end else if (md_pending) begin
            if (md_cnt <= 1) begin
                ifc.md_ready <= 1'b1;
                md_pending   <= 1'b0;
            end else begin
                md_cnt <= md_cnt - 1;
            end
        end
    end

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          lat;
        bit          hang;
        int          exp_lat;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        bit          exp_exc;
        bit          exp_to;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the START cycle.
    task automatic issue_req(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input int lat, input bit hang);
        md_lat           = lat;
        md_hang          = hang;
        ifc.issue_is_div = is_div;
        ifc.issue_opA    = a;
        ifc.issue_opB    = b;
        ifc.issue_rd     = rd;
        ifc.issue_valid  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ifc.issue_valid = 1'b0;
    endtask

    // Returns the cycle index (START = 1) of wb_valid, bounded by a cycle budget.
    task automatic wait_wb(output int k, output int st);
        k  = 1;
        st = 0;
        while (!ifc.wb_valid && k < 300) begin
            if (ifc.stall) st++;
            @(negedge clock);
            k++;
            if (k == 2) chk("pulse_one_cycle", {ifc.md_ctrl_mult, ifc.md_ctrl_div}, 0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k, st;
        issue_req(v.is_div, v.a, v.b, v.rd, v.lat, v.hang);
        chk("start_pulse", {ifc.md_ctrl_div, ifc.md_ctrl_mult}, v.is_div ? 32'd2 : 32'd1);
        chk("start_busy_rd", ifc.busy_rd, v.rd);
        chk("start_opA", ifc.md_operandA, v.a);
        wait_wb(k, st);
        chk("wb_latency", k, v.exp_lat);
        chk("stall_cycles", st, v.exp_lat - 1);
        chk("wb_rd", ifc.wb_rd, v.exp_rd);
        chk("wb_data", ifc.wb_data, v.exp_data);
        chk("wb_exception", ifc.wb_exception, v.exp_exc);
        chk("wb_timeout", ifc.wb_timeout, v.exp_to);
        chk("done_stall", ifc.stall, 0);
        chk("done_busy", ifc.busy, 1);
        chk("opB_held", ifc.md_operandB, v.b);
        @(negedge clock);
        chk("wb_single", ifc.wb_valid, 0);
        chk("idle_busy", ifc.busy, 0);
    endtask

    initial begin : guard
        #400000;
        $display("FAIL global_timeout: simulation did not finish within budget");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int k, st, seen;

        vecs[0] = '{0, 32'd7, 32'hFFFF_FFFD, 5'd5, 3, 0, 6, 5'd5, 32'hFFFF_FFEB, 0, 0};
        vecs[1] = '{1, 32'd100, 32'd7, 5'd9, 4, 0, 7, 5'd9, 32'd14, 0, 0};
        vecs[2] = '{1, 32'd5, 32'd0, 5'd12, 2, 0, 5, 5'd30, 32'd5, 1, 0};
        vecs[3] = '{0, 32'h4000_0000, 32'd4, 5'd7, 1, 0, 4, 5'd30, 32'd4, 1, 0};
        vecs[4] = '{0, 32'd6, 32'd6, 5'd0, 2, 0, 5, 5'd0, 32'd36, 0, 0};
        vecs[5] = '{1, 32'hFFFF_FFEC, 32'd3, 5'd3, 1, 0, 4, 5'd3, 32'hFFFF_FFFA, 0, 0};
        vecs[6] = '{0, 32'd2, 32'd3, 5'd8, 0, 1, 102, 5'd30, 32'd4, 1, 1};

        reset            = 1'b1;
        ifc.issue_valid  = 1'b0;
        ifc.issue_is_div = 1'b0;
        ifc.issue_opA    = '0;
        ifc.issue_opB    = '0;
        ifc.issue_rd     = '0;
        ifc.flush        = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_stall", ifc.stall, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_busy_rd", ifc.busy_rd, 0);
        chk("rst_ctrl", {ifc.md_ctrl_mult, ifc.md_ctrl_div}, 0);
        chk("rst_operandA", ifc.md_operandA, 0);
        chk("rst_operandB", ifc.md_operandB, 0);
        chk("rst_wb_valid", ifc.wb_valid, 0);
        chk("rst_wb_rd", ifc.wb_rd, 0);
        chk("rst_wb_data", ifc.wb_data, 0);
        chk("rst_wb_flags", {ifc.wb_exception, ifc.wb_timeout}, 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Flush three cycles into WAIT, then a normal op must still work.
        issue_req(0, 32'd11, 32'd11, 5'd2, 10, 0);
        repeat (3) @(negedge clock);
        chk("flush_pre_stall", ifc.stall, 1);
        @(negedge clock);
        ifc.flush = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ifc.flush = 1'b0;
        chk("flush_busy", ifc.busy, 0);
        chk("flush_stall", ifc.stall, 0);
        seen = 0;
        repeat (20) begin
            if (ifc.wb_valid) seen++;
            @(negedge clock);
        end
        chk("flush_no_wb", seen, 0);
        run_vec('{0, 32'd6, 32'd6, 5'd11, 2, 0, 5, 5'd11, 32'd36, 0, 0});

        // Flush and issue in the same cycle: request dropped.
        ifc.issue_is_div = 1'b0;
        ifc.issue_opA    = 32'd3;
        ifc.issue_opB    = 32'd3;
        ifc.issue_rd     = 5'd4;
        ifc.issue_valid  = 1'b1;
        ifc.flush        = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ifc.issue_valid = 1'b0;
        ifc.flush       = 1'b0;
        seen = 0;
        repeat (10) begin
            if (ifc.wb_valid || ifc.busy || ifc.md_ctrl_mult || ifc.md_ctrl_div) seen++;
            @(negedge clock);
        end
        chk("flush_issue_dropped", seen, 0);

        // Back-to-back: second request presented during DONE, stale md_ready in START.
        issue_req(0, 32'd3, 32'd5, 5'd4, 2, 0);
        wait_wb(k, st);
        chk("b2b_first_data", ifc.wb_data, 15);
        chk("b2b_first_rd", ifc.wb_rd, 4);
        issue_req(1, 32'd50, 32'd5, 5'd6, 2, 0);
        chk("b2b_start_div", {ifc.md_ctrl_div, ifc.md_ctrl_mult}, 2);
        chk("b2b_start_nowb", ifc.wb_valid, 0);
        chk("b2b_start_stall", ifc.stall, 1);
        chk("b2b_busy_rd", ifc.busy_rd, 6);
        wait_wb(k, st);
        chk("b2b_second_lat", k, 5);
        chk("b2b_second_data", ifc.wb_data, 10);
        chk("b2b_second_rd", ifc.wb_rd, 6);
        chk("b2b_second_exc", ifc.wb_exception, 0);

        // Flush during DONE: the visible writeback stands, the same-cycle issue is dropped.
        @(negedge clock);
        issue_req(0, 32'd2, 32'd2, 5'd1, 1, 0);
        wait_wb(k, st);
        chk("done_flush_wb", ifc.wb_valid, 1);
        chk("done_flush_data", ifc.wb_data, 4);
        ifc.flush       = 1'b1;
        ifc.issue_valid = 1'b1;
        ifc.issue_opA   = 32'd9;
        @(posedge clock);
        @(negedge clock);
        ifc.flush       = 1'b0;
        ifc.issue_valid = 1'b0;
        chk("done_flush_busy", ifc.busy, 0);
        chk("done_flush_nowb", ifc.wb_valid, 0);
        chk("done_flush_ctrl", {ifc.md_ctrl_mult, ifc.md_ctrl_div}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
